// File: rtl/rf_pkg.sv
// Shared defaults and write-decode helper for the multi-port integer register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // Widest address the decode helper accepts; callers size-cast into it.
    localparam int MAX_AW = 10;

    // One bit of a one-hot write decode: high when an enabled write targets
    // register idx. Register 0 is hardwired to zero, so it never decodes.
    function automatic logic wr_hit(input logic              en,
                                    input logic [MAX_AW-1:0] addr,
                                    input logic [MAX_AW-1:0] idx);
        return en && (addr == idx) && (addr != '0);
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits tracking long-latency accelerator results.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_en,
    input  logic [AW-1:0]   set_addr,
    input  logic            clr_en,
    input  logic [AW-1:0]   clr_addr,
    input  logic [NRD*AW-1:0] rs_addr,
    output logic [NRD-1:0]  rs_busy,
    output logic            any_busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;

    // Next busy state: a completion clears, a new issue sets, and the set
    // wins when both hit the same register in one cycle.
    always_comb begin
        // NOTE: every bit gets a value on every path, so no latch is inferred.
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            if (wr_hit(clr_en, MAX_AW'(clr_addr), MAX_AW'(i))) busy_d[i] = 1'b0;
            if (wr_hit(set_en, MAX_AW'(set_addr), MAX_AW'(i))) busy_d[i] = 1'b1;
        end
    end

    // Busy register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!reset) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Lookup from registered state only; same-cycle set/clear is not visible.
    always_comb begin
        rs_busy = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rs_addr[p*AW +: AW] != '0) rs_busy[p] = busy_q[rs_addr[p*AW +: AW]];
        end
    end

    assign any_busy = |busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file: NRD combinational reads, core (W0) and
// accelerator (W1) write ports, optional write-to-read bypass, busy scoreboard.
module reg_file_mp
    import rf_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                write_en,
    input  logic [AW-1:0]       rd,
    input  logic [XLEN-1:0]     data_in,
    input  logic                acc_write_en,
    input  logic [AW-1:0]       acc_rd,
    input  logic [XLEN-1:0]     acc_data_in,
    input  logic                busy_set_en,
    input  logic [AW-1:0]       busy_set_addr,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] data_out,
    output logic [NRD-1:0]      rs_busy,
    output logic                any_busy,
    output logic                write_conflict
);

    if (NRD < 1 || NRD > 4) begin : g_bad_nrd
        $fatal(1, "reg_file_mp: NRD must be in 1..4");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0 || AW > MAX_AW) begin : g_bad_nregs
        $fatal(1, "reg_file_mp: NREGS must be a power of 2 within the decode range");
    end

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic            conflict_q;
    logic            conflict_d;

    // Next storage state: W0 has priority over W1 on a shared target.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_hit(write_en, MAX_AW'(rd), MAX_AW'(i)))
                regs_d[i] = data_in;
            else if (wr_hit(acc_write_en, MAX_AW'(acc_rd), MAX_AW'(i)))
                regs_d[i] = acc_data_in;
        end
    end

    assign conflict_d = write_en && acc_write_en && (rd == acc_rd) && (rd != '0);

    // Storage and conflict flag; reset must leave no stale architectural state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the array is reset on purpose; stale registers must never survive a reset.
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
            conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
            conflict_q <= conflict_d;
        end
    end

    assign write_conflict = conflict_q;

    // Read mux per port with optional same-cycle forwarding (W0 before W1).
    always_comb begin
        data_out = '0;
        for (int p = 0; p < NRD; p++) begin
            // NOTE: blocking assignments here are combinational; only always_ff uses <=.
            logic [AW-1:0]   addr;
            logic [XLEN-1:0] val;
            addr = rs_addr[p*AW +: AW];
            val  = regs_q[addr];
            if (BYPASS != 0 && reset) begin
                if (write_en && rd == addr)
                    val = data_in;
                else if (acc_write_en && acc_rd == addr)
                    val = acc_data_in;
            end
            if (addr == '0) val = '0;
            data_out[p*XLEN +: XLEN] = val;
        end
    end

    rf_scoreboard #(
        .NREGS (NREGS),
        .NRD   (NRD),
        .AW    (AW)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (busy_set_en),
        .set_addr (busy_set_addr),
        .clr_en   (acc_write_en),
        .clr_addr (acc_rd),
        .rs_addr  (rs_addr),
        .rs_busy  (rs_busy),
        .any_busy (any_busy)
    );

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: one BYPASS=1 and one BYPASS=0 instance
// share stimulus; expectations are queued per cycle and checked at negedge.
module tb_reg_file_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic        write_en;
    logic [4:0]  rd;
    logic [31:0] data_in;
    logic        acc_write_en;
    logic [4:0]  acc_rd;
    logic [31:0] acc_data_in;
    logic        busy_set_en;
    logic [4:0]  busy_set_addr;
    logic [9:0]  rs_addr;

    logic [63:0] a_dout, b_dout;
    logic [1:0]  a_rs_busy, b_rs_busy;
    logic        a_any, b_any, a_conf, b_conf;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut_byp (
        .clk(clk), .reset(reset), .write_en(write_en), .rd(rd), .data_in(data_in),
        .acc_write_en(acc_write_en), .acc_rd(acc_rd), .acc_data_in(acc_data_in),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .rs_addr(rs_addr),
        .data_out(a_dout), .rs_busy(a_rs_busy), .any_busy(a_any), .write_conflict(a_conf)
    );

    reg_file_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nob (
        .clk(clk), .reset(reset), .write_en(write_en), .rd(rd), .data_in(data_in),
        .acc_write_en(acc_write_en), .acc_rd(acc_rd), .acc_data_in(acc_data_in),
        .busy_set_en(busy_set_en), .busy_set_addr(busy_set_addr), .rs_addr(rs_addr),
        .data_out(b_dout), .rs_busy(b_rs_busy), .any_busy(b_any), .write_conflict(b_conf)
    );

    // sel: 0/1 bypass-port0/1, 2/3 no-bypass port0/1, 4/5 rs_busy0/1,
    //      6 any_busy, 7 write_conflict, 8 no-bypass any_busy, 9 no-bypass conflict
    function automatic logic [31:0] actual(input int sel);
        case (sel)
            0:       return a_dout[31:0];
            1:       return a_dout[63:32];
            2:       return b_dout[31:0];
            3:       return b_dout[63:32];
            4:       return {31'd0, a_rs_busy[0]};
            5:       return {31'd0, a_rs_busy[1]};
            6:       return {31'd0, a_any};
            7:       return {31'd0, a_conf};
            8:       return {31'd0, b_any};
            9:       return {31'd0, b_conf};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: pop every expectation due this cycle and compare.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] act;
        while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
            e   = sb_q.pop_front();
            act = actual(e.sel);
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                errors++;
                $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d, due %0d)",
                         e.name, act, e.val, cyc, e.cyc);
            end
        end
    end

    task automatic expect_v(input int sel, input logic [31:0] v, input string name);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.val = v; e.name = name;
        sb_q.push_back(e);
    endtask

    task automatic expect_both(input int port, input logic [31:0] v, input string name);
        expect_v(port,     v, {name, "_byp"});
        expect_v(port + 2, v, {name, "_nob"});
    endtask

    task automatic drive(input logic rst, input logic we, input logic [4:0] a,
                         input logic [31:0] d, input logic awe, input logic [4:0] aa,
                         input logic [31:0] ad, input logic bse, input logic [4:0] ba,
                         input logic [4:0] r0, input logic [4:0] r1);
        reset = rst; write_en = we; rd = a; data_in = d;
        acc_write_en = awe; acc_rd = aa; acc_data_in = ad;
        busy_set_en = bse; busy_set_addr = ba;
        rs_addr = {r1, r0};
    endtask

    task automatic idle(input logic [4:0] r0, input logic [4:0] r1);
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, r0, r1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd0, 5'd0);
        tick(); tick();

        // Preload x5, then one reset edge with writes and a busy set that must be ignored.
        drive(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd5, 5'd0);
        tick();
        drive(1'b0, 1'b1, 5'd6, 32'h00000001, 1'b1, 5'd8, 32'h00000002, 1'b1, 5'd3, 5'd5, 5'd6);
        expect_both(0, 32'hDEADBEEF, "pre_reset_x5");
        expect_v(1, 32'h0, "no_bypass_in_reset");
        tick();
        idle(5'd5, 5'd6);
        expect_both(0, 32'h0, "reset_x5");
        expect_both(1, 32'h0, "reset_write_ignored");
        expect_v(6, 32'h0, "reset_any_busy");
        expect_v(7, 32'h0, "reset_conflict");
        tick();

        // Basic W0 write and read-back.
        drive(1'b1, 1'b1, 5'd2, 32'h01114444, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd2, 5'd0);
        expect_v(0, 32'h01114444, "bypass_x2");
        expect_v(2, 32'h0, "nobypass_x2_old");
        tick();
        idle(5'd2, 5'd0);
        expect_both(0, 32'h01114444, "read_x2");
        expect_both(1, 32'h0, "read_x0");
        tick();

        // Writes and busy set to x0 are discarded; both ports on x0 is no conflict.
        drive(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 5'd0, 5'd0);
        expect_both(0, 32'h0, "x0_same_cycle");
        tick();
        idle(5'd0, 5'd0);
        expect_both(0, 32'h0, "x0_after_write");
        expect_v(6, 32'h0, "x0_busy_ignored");
        expect_v(7, 32'h0, "x0_no_conflict");
        tick();

        // W0 bypass to both ports.
        drive(1'b1, 1'b1, 5'd4, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd4, 5'd4);
        expect_v(0, 32'h12345678, "bypass_x4_p0");
        expect_v(1, 32'h12345678, "bypass_x4_p1");
        expect_v(2, 32'h0, "nobypass_x4_old");
        tick();
        idle(5'd4, 5'd0);
        expect_both(0, 32'h12345678, "read_x4");
        tick();

        // W1 bypass.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h0BADCAFE, 1'b0, 5'd0, 5'd0, 5'd10);
        expect_v(1, 32'h0BADCAFE, "bypass_acc_x10");
        expect_v(3, 32'h0, "nobypass_acc_x10_old");
        tick();
        idle(5'd0, 5'd10);
        expect_both(1, 32'h0BADCAFE, "read_x10");
        tick();

        // Conflict: W0 wins, pulse for exactly one cycle.
        drive(1'b1, 1'b1, 5'd7, 32'hAAAA0000, 1'b1, 5'd7, 32'h5555FFFF, 1'b0, 5'd0, 5'd7, 5'd0);
        expect_v(0, 32'hAAAA0000, "bypass_w0_priority");
        expect_v(7, 32'h0, "conflict_not_yet");
        tick();
        idle(5'd7, 5'd0);
        expect_both(0, 32'hAAAA0000, "conflict_w0_wins");
        expect_v(7, 32'h1, "conflict_pulse");
        expect_v(9, 32'h1, "conflict_pulse_nob");
        tick();
        idle(5'd7, 5'd0);
        expect_v(7, 32'h0, "conflict_cleared");
        tick();

        // Scoreboard: set x9, visible only after the edge.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        expect_v(4, 32'h0, "busy_set_not_bypassed");
        expect_v(6, 32'h0, "any_busy_not_bypassed");
        tick();
        idle(5'd9, 5'd0);
        expect_v(4, 32'h1, "busy_x9");
        expect_v(5, 32'h0, "busy_x0_port");
        expect_v(6, 32'h1, "any_busy_set");
        expect_v(8, 32'h1, "any_busy_set_nob");
        tick();

        // W1 completion clears busy on the next cycle.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 5'd9, 5'd0);
        expect_v(4, 32'h1, "busy_clear_not_bypassed");
        expect_v(0, 32'hCAFEF00D, "bypass_x9");
        tick();
        idle(5'd9, 5'd0);
        expect_v(4, 32'h0, "busy_x9_cleared");
        expect_v(6, 32'h0, "any_busy_cleared");
        expect_both(0, 32'hCAFEF00D, "read_x9");
        tick();

        // W0 writes leave busy bits alone.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 5'd9, 5'd0);
        tick();
        drive(1'b1, 1'b1, 5'd9, 32'h00000077, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 5'd9, 5'd0);
        tick();
        idle(5'd9, 5'd0);
        expect_v(4, 32'h1, "w0_keeps_busy");
        expect_both(0, 32'h00000077, "w0_write_busy_reg");
        tick();

        // Same-cycle clear and set of x9: set wins, data still written.
        drive(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h11111111, 1'b1, 5'd9, 5'd9, 5'd0);
        tick();
        idle(5'd9, 5'd0);
        expect_v(4, 32'h1, "set_beats_clear");
        expect_v(6, 32'h1, "set_beats_clear_any");
        expect_both(0, 32'h11111111, "set_clear_data");
        tick();

        // Reset mid-busy, with a conflict presented in the reset cycle.
        drive(1'b0, 1'b1, 5'd12, 32'h1, 1'b1, 5'd12, 32'h2, 1'b0, 5'd0, 5'd9, 5'd7);
        tick();
        idle(5'd9, 5'd7);
        expect_v(4, 32'h0, "reset_clears_busy");
        expect_v(6, 32'h0, "reset_clears_any");
        expect_v(7, 32'h0, "reset_blocks_conflict");
        expect_both(0, 32'h0, "reset_clears_x9");
        expect_both(1, 32'h0, "reset_clears_x7");
        tick();

        tick(); tick();
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file for the RV32 core. Generalises the existing 2R/1W register file.
- Adds a configurable number of read ports, a second write port for GEMM accelerator writeback, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for long-latency accelerator results.
- Sits between decode/operand fetch and the writeback stage.
- The accelerator interface uses the second write port and the scoreboard.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of registers (power of 2). AW = $clog2(NREGS).
- NRD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a write in the current cycle is forwarded to any matching read port; 0 = reads return the stored value only.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- write_en  in  1  core writeback enable (port W0).
- rd  in  AW  W0 destination address.
- data_in  in  XLEN  W0 write data.
- acc_write_en  in  1  accelerator writeback enable (port W1).
- acc_rd  in  AW  W1 destination address.
- acc_data_in  in  XLEN  W1 write data.
- busy_set_en  in  1  mark a register as pending an accelerator result.
- busy_set_addr  in  AW  register to mark.
- rs_addr  in  NRD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- data_out  out  NRD*XLEN  packed read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy  out  NRD  busy bit of each read port's addressed register.
- any_busy  out  1  OR of all busy bits.
- write_conflict  out  1  registered pulse: W0 and W1 targeted the same nonzero register in the previous cycle.

Behaviour:
- Reset:
  - Synchronous, active-low. On a rising edge with reset=0, all registers, all busy bits and write_conflict clear to 0 in that one edge.
  - Writes and busy sets presented in a reset cycle are ignored.
  - Reset asserted mid-operation discards pending busy state; no partial state survives.
- Reads:
  - Combinational; zero-cycle latency from rs_addr to data_out.
  - Address 0 always reads 0, and its rs_busy is always 0.
- Writes:
  - Occur on the rising edge when reset=1 and the enable is high. Writes to address 0 are discarded.
  - Both ports targeting the same nonzero register: W0 (core) wins and W1 data is dropped. write_conflict=1 for exactly the next cycle; otherwise write_conflict=0.
- Bypass:
  - Applies when BYPASS=1 and reset=1. A read port whose address matches a same-cycle enabled write to a nonzero register returns that write's data.
  - W0 data is forwarded in preference to W1 data.
  - When BYPASS=0, the new value is visible from the cycle after the edge.
- Scoreboard:
  - busy_set_en sets busy[busy_set_addr] on the edge; address 0 is ignored.
  - An enabled W1 write clears busy[acc_rd]. W0 writes do not affect busy bits.
  - Set and clear of the same register in one cycle: the set wins, leaving busy=1 (a new issue following completion).
  - A W1 write to a register that is not busy still writes and clears the bit (no-op).
  - rs_busy and any_busy are combinational from the registered busy bits, with no bypass of same-cycle set/clear.
- Out-of-range parameters (NRD outside 1..4, NREGS not a power of 2) are a fatal elaboration error.

Decomposition:
- Package rf_pkg holds the XLEN and NREGS defaults and a function for a one-hot write decode.
- One sub-module, rf_scoreboard: the NREGS busy bits, set/clear priority, rs_busy lookup and any_busy.
- Storage, write arbitration and the bypass mux stay in reg_file_mp.

Test Plan:
- Reset/idle: hold reset=0 for 1 edge after preloading x5=0xDEADBEEF, then release. Required: data_out on all ports =0, any_busy=0, write_conflict=0.
- Basic write/read: write W0 x2=0x01114444, next cycle rs_addr[0]=2, rs_addr[1]=0. Required: port0=0x01114444, port1=0.
- x0 write: write_en=1, rd=0, data 0xFFFFFFFF, then read x0. Required: 0.
- Bypass:
  - BYPASS=1: write x4=0x12345678 with rs_addr[0]=4 in the same cycle. Required: port0=0x12345678 that cycle.
  - BYPASS=0: the same stimulus returns the old value that cycle and the new value the next cycle.
- Conflict: in one cycle, W0 writes x7=0xAAAA0000 and W1 writes x7=0x5555FFFF. Required: x7 reads 0xAAAA0000, and write_conflict=1 for one cycle then 0.
- Scoreboard:
  - busy_set x9 → rs_busy for x9=1, any_busy=1.
  - Then W1 writes x9=0xCAFEF00D → busy clears next cycle and x9 reads 0xCAFEF00D.
  - Same-cycle busy_set x9 with W1 write x9 → busy stays 1.
  - Reset mid-busy → busy clears.
